// File: rtl/filter_kernel_sequencer.sv
// filter_kernel_sequencer: arbitrates kernel-select requests from two requesters,
// applies the winning config at a frame boundary and holds bypass during line-buffer warm-up.
module filter_kernel_sequencer #(
  parameter int unsigned HRES           = 1280,
  parameter int unsigned VRES           = 720,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter logic [2:0]  DEFAULT_KERNEL = 3'd0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_a_in,
  input  logic [2:0]  cfg_a_in,
  input  logic        req_b_in,
  input  logic [2:0]  cfg_b_in,
  output logic        grant_a_out,
  output logic        grant_b_out,
  input  logic        data_valid_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        data_valid_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic [2:0]  kernel_sel_out,
  output logic        bypass_out,
  output logic        busy_out,
  output logic [7:0]  frame_count_out
);

  localparam int unsigned HCW = 11;
  localparam int unsigned VCW = 10;
  localparam int unsigned LCW = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;

  localparam logic [HCW-1:0] LAST_COL   = HCW'(HRES - 1);
  localparam logic [LCW:0]   WARM_LINES = (LCW + 1)'(KERNEL_SIZE - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PENDING = 2'd1;
  localparam logic [1:0] WARMUP  = 2'd2;

  // Parameter sanity: timing counters are fixed-width and warm-up needs at least one line.
  if (HRES < 2 || HRES > 2048 || VRES < 1 || VRES > 1024 || KERNEL_SIZE < 2) begin : g_param_check
    $error("filter_kernel_sequencer: unsupported HRES/VRES/KERNEL_SIZE");
  end

  logic [1:0]     state_q, state_d;
  logic [2:0]     pending_q, pending_d;
  logic [2:0]     ksel_d;
  logic           bypass_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic [LCW:0]   line_inc_c;
  logic           ptr_b_q, ptr_b_d;
  logic           frame_start_c, line_end_c;
  logic           eligible_c, grant_a_c, grant_b_c;

  // Pixel-stream event decode.
  assign frame_start_c = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign line_end_c    = data_valid_in && (hcount_in == LAST_COL);
  assign line_inc_c    = {1'b0, line_cnt_q} + (LCW + 1)'(1);

  // Round-robin arbitration; ptr_b_q=1 means B wins the next tie.
  assign eligible_c = ((state_q == IDLE) || (state_q == PENDING)) && !frame_start_c;
  assign grant_a_c  = eligible_c && req_a_in && (!req_b_in || !ptr_b_q);
  assign grant_b_c  = eligible_c && req_b_in && (!req_a_in || ptr_b_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ksel_d     = kernel_sel_out;
    bypass_d   = bypass_out;
    line_cnt_d = line_cnt_q;
    ptr_b_d    = ptr_b_q;

    if (grant_a_c) begin
      pending_d = cfg_a_in;
      ptr_b_d   = 1'b1;
    end else if (grant_b_c) begin
      pending_d = cfg_b_in;
      ptr_b_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (grant_a_c || grant_b_c) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (frame_start_c) begin
          ksel_d     = pending_q;
          bypass_d   = 1'b1;
          line_cnt_d = '0;
          state_d    = WARMUP;
        end
      end
      WARMUP: begin
        if (frame_start_c) begin
          line_cnt_d = '0;
        end else if (line_end_c) begin
          if (line_inc_c == WARM_LINES) begin
            line_cnt_d = '0;
            bypass_d   = 1'b0;
            state_d    = IDLE;
          end else begin
            line_cnt_d = line_inc_c[LCW-1:0];
          end
        end
      end
      default: begin
        state_d  = IDLE;
        bypass_d = 1'b0;
      end
    endcase
  end

  // State register and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q         <= IDLE;
      pending_q       <= DEFAULT_KERNEL;
      line_cnt_q      <= '0;
      ptr_b_q         <= 1'b0;
      kernel_sel_out  <= DEFAULT_KERNEL;
      bypass_out      <= 1'b0;
      busy_out        <= 1'b0;
      grant_a_out     <= 1'b0;
      grant_b_out     <= 1'b0;
      data_valid_out  <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_count_out <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      line_cnt_q      <= line_cnt_d;
      ptr_b_q         <= ptr_b_d;
      kernel_sel_out  <= ksel_d;
      bypass_out      <= bypass_d;
      busy_out        <= (state_d == PENDING);
      grant_a_out     <= grant_a_c;
      grant_b_out     <= grant_b_c;
      data_valid_out  <= data_valid_in;
      hcount_out      <= hcount_in;
      vcount_out      <= VCW'(vcount_in);
      frame_count_out <= frame_count_out + 8'(frame_start_c);
    end
  end

endmodule

// File: tb/tb_filter_kernel_sequencer.sv
// Self-checking bench for filter_kernel_sequencer.
module tb_filter_kernel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [2:0]  cfg_a = '0, cfg_b = '0;
  logic        dv = 1'b0;
  logic [10:0] hc = '0;
  logic [9:0]  vc = '0;
  logic        grant_a, grant_b, dv_o, bypass, busy;
  logic [10:0] hc_o;
  logic [9:0]  vc_o;
  logic [2:0]  ksel;
  logic [7:0]  fc;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_fc = '0;

  typedef struct packed {
    logic        dv;
    logic [10:0] h;
    logic [9:0]  v;
  } px_t;
  px_t sb_q[$];

  filter_kernel_sequencer dut (
    .clk_in(clk), .rst_in(rst_n),
    .req_a_in(req_a), .cfg_a_in(cfg_a), .req_b_in(req_b), .cfg_b_in(cfg_b),
    .grant_a_out(grant_a), .grant_b_out(grant_b),
    .data_valid_in(dv), .hcount_in(hc), .vcount_in(vc),
    .data_valid_out(dv_o), .hcount_out(hc_o), .vcount_out(vc_o),
    .kernel_sel_out(ksel), .bypass_out(bypass), .busy_out(busy),
    .frame_count_out(fc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic d, input logic [10:0] h, input logic [9:0] v);
    dv = d; hc = h; vc = v;
    if (d && h == 11'd0 && v == 10'd0) exp_fc = exp_fc + 8'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_a = 1'($urandom); req_b = 1'($urandom);
      cfg_a = 3'($urandom); cfg_b = 3'($urandom);
      dv = 1'($urandom); hc = 11'($urandom); vc = 10'($urandom);
      step();
      n_cmp++;
      if ({grant_a, grant_b, dv_o, bypass, busy} !== 5'b0) begin
        n_err++; $display("FAIL reset_flags: got %b want 00000", {grant_a, grant_b, dv_o, bypass, busy});
      end
      n_cmp++;
      if (hc_o !== 11'd0 || vc_o !== 10'd0 || ksel !== 3'd0 || fc !== 8'd0) begin
        n_err++; $display("FAIL reset_values: got h=%0d v=%0d ksel=%0d fc=%0d want all 0", hc_o, vc_o, ksel, fc);
      end
    end
    rst_n = 1'b1; exp_fc = '0;
    req_a = 1'b0; req_b = 1'b0; px(1'b0, 11'd0, 10'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({grant_a, grant_b, busy} !== 3'b0 || ksel !== 3'd0) begin
        n_err++; $display("FAIL idle_no_grant: got g=%b%b busy=%b ksel=%0d want 0", grant_a, grant_b, busy, ksel);
      end
    end
  endtask

  task automatic test_passthrough();
    px_t e;
    for (int i = 0; i < 20; i++) begin
      e.dv = 1'($urandom); e.h = 11'($urandom_range(0, 1279)); e.v = 10'($urandom_range(1, 719));
      px(e.dv, e.h, e.v);
      sb_q.push_back(e);
      step();
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL passthrough_queue: got empty want entry");
      end else begin
        e = sb_q.pop_front();
        if (dv_o !== e.dv || hc_o !== e.h || vc_o !== e.v || bypass !== 1'b0) begin
          n_err++;
          $display("FAIL passthrough: got dv=%b h=%0d v=%0d byp=%b want dv=%b h=%0d v=%0d byp=0",
                   dv_o, hc_o, vc_o, bypass, e.dv, e.h, e.v);
        end
      end
    end
    px(1'b0, 11'd0, 10'd1);
    step();
  endtask

  task automatic test_single();
    px(1'b1, 11'd100, 10'd50); req_a = 1'b1; cfg_a = 3'd5;
    step();
    n_cmp++;
    if (grant_a !== 1'b1 || grant_b !== 1'b0 || busy !== 1'b1 || ksel !== 3'd0) begin
      n_err++; $display("FAIL single_grant: got ga=%b gb=%b busy=%b ksel=%0d want 1 0 1 0", grant_a, grant_b, busy, ksel);
    end
    req_a = 1'b0;
    step();
    n_cmp++;
    if (grant_a !== 1'b0 || busy !== 1'b1 || ksel !== 3'd0) begin
      n_err++; $display("FAIL single_pulse: got ga=%b busy=%b ksel=%0d want 0 1 0", grant_a, busy, ksel);
    end
    px(1'b1, 11'd0, 10'd0);
    step();
    n_cmp++;
    if (ksel !== 3'd5 || bypass !== 1'b1 || busy !== 1'b0 || fc !== exp_fc || hc_o !== 11'd0) begin
      n_err++; $display("FAIL single_apply: got ksel=%0d byp=%b busy=%b fc=%0d want 5 1 0 %0d", ksel, bypass, busy, fc, exp_fc);
    end
    px(1'b1, 11'd1279, 10'd0);
    step();
    n_cmp++;
    if (bypass !== 1'b1) begin
      n_err++; $display("FAIL single_line0: got byp=%b want 1", bypass);
    end
    px(1'b1, 11'd1279, 10'd1);
    step();
    n_cmp++;
    if (bypass !== 1'b0 || hc_o !== 11'd1279 || vc_o !== 10'd1 || ksel !== 3'd5) begin
      n_err++; $display("FAIL single_bypass_drop: got byp=%b h=%0d v=%0d ksel=%0d want 0 1279 1 5", bypass, hc_o, vc_o, ksel);
    end
  endtask

  task automatic test_back_to_back();
    px(1'b1, 11'd20, 10'd3); req_a = 1'b1; cfg_a = 3'd1;
    step();
    cfg_a = 3'd7;
    step();
    n_cmp++;
    if (grant_a !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_regrant: got ga=%b busy=%b want 1 1", grant_a, busy);
    end
    req_a = 1'b0;
    step();
    px(1'b1, 11'd0, 10'd0);
    step();
    n_cmp++;
    if (ksel !== 3'd7 || bypass !== 1'b1) begin
      n_err++; $display("FAIL b2b_last_wins: got ksel=%0d byp=%b want 7 1", ksel, bypass);
    end
    px(1'b1, 11'd1279, 10'd0); step();
    px(1'b1, 11'd1279, 10'd1); step();
    px(1'b0, 11'd0, 10'd2);
  endtask

  task automatic test_tie();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; cfg_a = 3'd2; cfg_b = 3'd3;
    px(1'b0, 11'd0, 10'd0);
    step(); step();
    n_cmp++;
    if (grant_a !== 1'b0 || grant_b !== 1'b0 || ksel !== 3'd0) begin
      n_err++; $display("FAIL tie_in_reset: got ga=%b gb=%b ksel=%0d want 0 0 0", grant_a, grant_b, ksel);
    end
    rst_n = 1'b1; exp_fc = '0;
    step();
    n_cmp++;
    if (grant_a !== 1'b1 || grant_b !== 1'b0) begin
      n_err++; $display("FAIL tie_first_a: got ga=%b gb=%b want 1 0", grant_a, grant_b);
    end
    req_a = 1'b0;
    step();
    n_cmp++;
    if (grant_a !== 1'b0 || grant_b !== 1'b1) begin
      n_err++; $display("FAIL tie_then_b: got ga=%b gb=%b want 0 1", grant_a, grant_b);
    end
    req_b = 1'b0;
    step();
    px(1'b1, 11'd0, 10'd0);
    step();
    n_cmp++;
    if (ksel !== 3'd3 || bypass !== 1'b1 || fc !== exp_fc) begin
      n_err++; $display("FAIL tie_apply: got ksel=%0d byp=%b fc=%0d want 3 1 %0d", ksel, bypass, fc, exp_fc);
    end
    px(1'b1, 11'd1279, 10'd0); step();
    px(1'b1, 11'd1279, 10'd1); step();
    px(1'b1, 11'd7, 10'd2);
  endtask

  task automatic test_collision();
    px(1'b1, 11'd0, 10'd0); req_a = 1'b1; cfg_a = 3'd6;
    step();
    n_cmp++;
    if (grant_a !== 1'b0 || busy !== 1'b0 || ksel !== 3'd3 || bypass !== 1'b0) begin
      n_err++; $display("FAIL collide_hold: got ga=%b busy=%b ksel=%0d byp=%b want 0 0 3 0", grant_a, busy, ksel, bypass);
    end
    px(1'b1, 11'd10, 10'd0);
    step();
    n_cmp++;
    if (grant_a !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL collide_grant_next: got ga=%b busy=%b want 1 1", grant_a, busy);
    end
    req_a = 1'b0; px(1'b1, 11'd11, 10'd0);
    step();
    n_cmp++;
    if (ksel !== 3'd3) begin
      n_err++; $display("FAIL collide_not_current: got ksel=%0d want 3", ksel);
    end
    px(1'b1, 11'd0, 10'd0);
    step();
    n_cmp++;
    if (ksel !== 3'd6 || bypass !== 1'b1 || fc !== exp_fc) begin
      n_err++; $display("FAIL collide_apply: got ksel=%0d byp=%b fc=%0d want 6 1 %0d", ksel, bypass, fc, exp_fc);
    end
  endtask

  task automatic test_warmup_holdoff();
    logic [10:0] hs[4] = '{11'd1279, 11'd0, 11'd1279, 11'd1279};
    logic [9:0]  vs[4] = '{10'd0, 10'd0, 10'd0, 10'd1};
    logic        eb[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    req_b = 1'b1; cfg_b = 3'd4;
    for (int i = 0; i < 4; i++) begin
      px(1'b1, hs[i], vs[i]);
      step();
      n_cmp++;
      if (bypass !== eb[i] || grant_b !== 1'b0 || ksel !== 3'd6) begin
        n_err++; $display("FAIL warmup_step%0d: got byp=%b gb=%b ksel=%0d want %b 0 6", i, bypass, grant_b, ksel, eb[i]);
      end
    end
    px(1'b1, 11'd5, 10'd2);
    step();
    n_cmp++;
    if (grant_b !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL warmup_release: got gb=%b busy=%b want 1 1", grant_b, busy);
    end
    req_b = 1'b0;
    step();
    n_cmp++;
    if (grant_b !== 1'b0) begin
      n_err++; $display("FAIL warmup_pulse: got gb=%b want 0", grant_b);
    end
  endtask

  task automatic test_reset_midwarm();
    px(1'b1, 11'd0, 10'd0);
    step();
    n_cmp++;
    if (bypass !== 1'b1 || ksel !== 3'd4) begin
      n_err++; $display("FAIL midwarm_enter: got byp=%b ksel=%0d want 1 4", bypass, ksel);
    end
    rst_n = 1'b0; px(1'b0, 11'd0, 10'd0);
    step();
    n_cmp++;
    if (bypass !== 1'b0 || ksel !== 3'd0 || busy !== 1'b0 || fc !== 8'd0) begin
      n_err++; $display("FAIL midwarm_reset: got byp=%b ksel=%0d busy=%b fc=%0d want 0 0 0 0", bypass, ksel, busy, fc);
    end
    rst_n = 1'b1; exp_fc = '0;
    for (int i = 1; i <= 257; i++) begin
      px(1'b1, 11'd0, 10'd0);
      step();
      if (i == 256) begin
        n_cmp++;
        if (fc !== 8'd0) begin
          n_err++; $display("FAIL frame_wrap_256: got fc=%0d want 0", fc);
        end
      end
    end
    n_cmp++;
    if (fc !== exp_fc || fc !== 8'd1) begin
      n_err++; $display("FAIL frame_wrap_257: got fc=%0d want 1", fc);
    end
    px(1'b0, 11'd0, 10'd0);
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_single();
    test_back_to_back();
    test_tie();
    test_collision();
    test_warmup_holdoff();
    test_reset_midwarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
